// File: rtl/button_events_pkg.sv
// button_events_pkg
//   Shared definitions for the button event decoder: the per-channel state
//   encoding, default hold/repeat timings and a small elaboration helper.
package button_events_pkg;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_HELD,
        CH_REPEAT
    } ch_state_e;

    localparam int unsigned DEFAULT_LONG_CYCLES   = 12_000_000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES = 3_000_000;

    // Larger of two timings; sizes the shared per-channel counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_events_if.sv
// button_events_if
//   Groups the button levels and the decoded event outputs of button_events.
//   master : drives btn_i, observes the events (button source / consumer side)
//   slave  : the decoder itself (samples btn_i, drives the event outputs)
//   Signals (all N_BTN wide, one bit per channel):
//     btn_i     debounced clk-synchronous button level, 1 = pressed
//     press_o   one-cycle pulse on press
//     release_o one-cycle pulse on release
//     long_o    one-cycle pulse when the hold reaches the long-press time
//     repeat_o  one-cycle auto-repeat pulse while held past long press
//     held_o    level, 1 while the channel is not idle
interface button_events_if #(
    parameter int unsigned N_BTN = 2
) ();

    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic [N_BTN-1:0] long_o;
    logic [N_BTN-1:0] repeat_o;
    logic [N_BTN-1:0] held_o;

    modport master (
        output btn_i,
        input  press_o,
        input  release_o,
        input  long_o,
        input  repeat_o,
        input  held_o
    );

    modport slave (
        input  btn_i,
        output press_o,
        output release_o,
        output long_o,
        output repeat_o,
        output held_o
    );

endinterface

// File: rtl/button_event_ch.sv
// button_event_ch
//   One button channel: detects press/release edges and times long press and
//   auto-repeat. All outputs are registered.
//   Ports:
//     clk       system clock, rising edge
//     rst_ni    asynchronous active-low reset
//     btn_i     debounced, clk-synchronous button level (1 = pressed)
//     press_o   one-cycle pulse, cycle after the rising level is sampled
//     release_o one-cycle pulse, cycle after the low level is sampled
//     long_o    one-cycle pulse LONG_CYCLES cycles after press_o
//     repeat_o  one-cycle pulse every REPEAT_CYCLES cycles after long_o
//     held_o    1 from the press_o cycle up to the cycle before release_o
module button_event_ch
    import button_events_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int unsigned CNT_MAX = max_u(LONG_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             prev_q;
    logic             press_d, release_d, long_d, repeat_d, held_d;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            prev_q    <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            prev_q    <= btn_i;
            press_o   <= press_d;
            release_o <= release_d;
            long_o    <= long_d;
            repeat_o  <= repeat_d;
            held_o    <= held_d;
        end
    end

    // The counter equals the number of held edges since press, so the long
    // pulse is issued when it reaches LONG_CYCLES-1 with the button still down.
    // Release is tested first, which suppresses a coinciding long/repeat.
    // Without auto-repeat the count saturates; sat_q stops a second long pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            CH_IDLE: begin
                if (btn_i && !prev_q) begin
                    state_d = CH_HELD;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    press_d = 1'b1;
                end
            end

            CH_HELD: begin
                if (!btn_i) begin
                    state_d   = CH_IDLE;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    release_d = 1'b1;
                end else if (!sat_q) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                        if (REPEAT_EN) begin
                            state_d = CH_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            sat_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            CH_REPEAT: begin
                if (!btn_i) begin
                    state_d   = CH_IDLE;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    release_d = 1'b1;
                end else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        endcase

        held_d = (state_d != CH_IDLE);
    end

endmodule

// File: rtl/button_events.sv
// button_events
//   Press / release / long-press / auto-repeat event decoder for N_BTN
//   independent, already debounced buttons.
//   Ports:
//     clk     system clock, rising edge
//     rst_ni  asynchronous active-low reset
//     bus     button_events_if slave: btn_i in; press_o, release_o, long_o,
//             repeat_o, held_o out (one bit per channel)
module button_events
    import button_events_pkg::*;
#(
    parameter int unsigned N_BTN         = 2,
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_ni,
    button_events_if.slave bus
);

    logic [N_BTN-1:0] press, rel, lng, rep, held;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_event_ch #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN)
        ) u_ch (
            .clk       (clk),
            .rst_ni    (rst_ni),
            .btn_i     (bus.btn_i[g]),
            .press_o   (press[g]),
            .release_o (rel[g]),
            .long_o    (lng[g]),
            .repeat_o  (rep[g]),
            .held_o    (held[g])
        );
    end

    assign bus.press_o   = press;
    assign bus.release_o = rel;
    assign bus.long_o    = lng;
    assign bus.repeat_o  = rep;
    assign bus.held_o    = held;

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter: N_BTN, default 2, number of independent button channels.
REQ-002 Parameter: LONG_CYCLES, default 12_000_000, cycles from press_o to long_o; SHALL be >= 2.
REQ-003 Parameter: REPEAT_CYCLES, default 3_000_000, cycles between auto-repeat pulses; SHALL be >= 2.
REQ-004 Parameter: REPEAT_EN, default 1, enables auto-repeat after long press (0 = long_o only).
REQ-005 Port: clk  input  1  system clock; all logic on rising edge.
REQ-006 Port: rst_ni  input  1  asynchronous active-low reset.
REQ-007 Port: btn_i  input  N_BTN  debounced, clk-synchronous button levels from debouncer instances (1 = pressed).
REQ-008 Port: press_o  output  N_BTN  one-cycle pulse per channel on press.
REQ-009 Port: release_o  output  N_BTN  one-cycle pulse per channel on release.
REQ-010 Port: long_o  output  N_BTN  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-011 Port: repeat_o  output  N_BTN  one-cycle auto-repeat pulse while held past long press.
REQ-012 Port: held_o  output  N_BTN  level, 1 while channel FSM not IDLE.

Function
REQ-013 Each channel SHALL be fully independent; no cross-channel interaction, simultaneous events on different channels produce same-cycle pulses.
REQ-014 Each channel SHALL register btn_i once (prev bit); edge = btn_i XOR prev, no further synchronisation.
REQ-015 Channel FSM states SHALL be IDLE, HELD, REPEAT; one counter per channel, width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)).
REQ-016 IDLE: btn_i sampled 1 with prev 0 at edge k -> press_o=1 during cycle k+1, FSM -> HELD, counter cleared.
REQ-017 HELD: counter increments each cycle btn_i=1; long_o SHALL pulse exactly LONG_CYCLES cycles after press_o, FSM -> REPEAT (REPEAT_EN=1) or stays HELD with counter saturated (REPEAT_EN=0), counter cleared on REPEAT entry.
REQ-018 REPEAT: repeat_o SHALL pulse every REPEAT_CYCLES cycles, first one REPEAT_CYCLES cycles after long_o; counter wraps to 0 on each pulse.
REQ-019 Any non-IDLE state: btn_i sampled 0 at edge k -> release_o=1 during cycle k+1, FSM -> IDLE, counter cleared.
REQ-020 Release coinciding with long_o or repeat_o cycle: release_o SHALL win; long_o/repeat_o suppressed.
REQ-021 All outputs SHALL be registered; pulses never exceed one cycle; press_o and release_o never both high on one channel.
REQ-022 held_o SHALL be 1 from the press_o cycle through the cycle before release_o, inclusive.

Reset
REQ-023 rst_ni low SHALL asynchronously force all FSMs to IDLE, counters and prev to 0, all outputs to 0.
REQ-024 Reset mid-hold SHALL discard the hold; no release_o emitted.
REQ-025 Button held across reset deassertion SHALL yield press_o one cycle after the first rising clk edge with rst_ni high.

Structure
REQ-026 Package button_events_pkg SHALL hold the channel state enum typedef and default LONG/REPEAT constants.
REQ-027 Sub-module button_event_ch SHALL implement one channel; button_events SHALL generate N_BTN instances.

Verification (N_BTN=2, LONG_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1, btn rise sampled at edge 0)
REQ-028 btn_i[0] high 5 cycles -> press_o[0] at cycle 1, release_o[0] at cycle 6, no long_o/repeat_o.
REQ-029 btn_i[0] high 8 cycles -> press at 1, release at 9, long_o suppressed (REQ-020).
REQ-030 btn_i[0] high 20 cycles -> press 1, long 9, repeat 13 and 17, release 21, repeat at 21 suppressed.
REQ-031 btn_i=2'b11 high 10 cycles -> press_o=2'b11 at 1, long_o=2'b11 at 9, release_o=2'b11 at 11.
REQ-032 rst_ni low at cycle 5 of hold, high at cycle 7, btn still high -> outputs 0 during reset, no release_o, press_o one cycle after first clk edge post-deassertion, long_o 8 cycles later.
